// File: rtl/common_types_pkg.sv
// Shared type definitions for the memory arbiter: FSM states and grant kinds.
package common_types_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

endpackage : common_types_pkg

// File: rtl/memory_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch and data
// ports; data has fixed priority, and every access takes RAM_LAT cycles plus a response cycle.
module memory_arbiter
  import common_types_pkg::*;
#(
  parameter int unsigned RAM_LAT = 1,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iren,
  input  logic [ADDR_W-1:0]   iaddr,
  output logic [DATA_W-1:0]   iload,
  output logic                iwait,
  input  logic                dren,
  input  logic [DATA_W/8-1:0] dwen,
  input  logic [ADDR_W-1:0]   daddr,
  input  logic [DATA_W-1:0]   dstore,
  output logic [DATA_W-1:0]   dload,
  output logic                dwait,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_ren,
  output logic [DATA_W/8-1:0] ram_wen,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(RAM_LAT + 1);

  arb_state_t          state_q;
  arb_grant_t          kind_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BE_W-1:0]     wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ram_ren_q;
  logic [BE_W-1:0]     ram_wen_q;
  logic [DATA_W-1:0]   iload_q;
  logic [DATA_W-1:0]   dload_q;

  logic d_pend;
  logic match_i, match_d;
  logic hit_i, hit_d;
  logic req_i, req_d;
  logic grant;

  always_comb begin
    d_pend  = dren | (|dwen);
    match_i = iren && (iaddr == addr_q);
    match_d = d_pend && (daddr == addr_q) && (dwen == wen_q) && (dstore == wdata_q);
    hit_i   = (state_q == ARB_RESP) && (kind_q == GRANT_I) && match_i;
    hit_d   = (state_q == ARB_RESP) && (kind_q == GRANT_D) && match_d;
    // Only the requester that just hit is excluded; an unmatched one may re-grant at once.
    req_i   = iren && !hit_i;
    req_d   = d_pend && !hit_d;
    grant   = (state_q != ARB_ACCESS) && (req_i || req_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      kind_q    <= GRANT_I;
      cnt_q     <= '0;
      addr_q    <= '0;
      wen_q     <= '0;
      wdata_q   <= '0;
      ram_ren_q <= 1'b0;
      ram_wen_q <= '0;
      iload_q   <= '0;
      dload_q   <= '0;
    end else begin
      case (state_q)
        ARB_ACCESS: begin
          ram_wen_q <= '0;
          if (cnt_q == '0) begin
            ram_ren_q <= 1'b0;
            state_q   <= ARB_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          if (hit_i) iload_q <= ram_rdata;
          if (hit_d) dload_q <= ram_rdata;
          if (grant) begin
            cnt_q   <= CNT_W'(RAM_LAT - 1);
            state_q <= ARB_ACCESS;
            if (req_d) begin
              kind_q    <= GRANT_D;
              addr_q    <= daddr;
              wen_q     <= dwen;
              wdata_q   <= dstore;
              ram_ren_q <= ~|dwen;
              ram_wen_q <= dwen;
            end else begin
              kind_q    <= GRANT_I;
              addr_q    <= iaddr;
              wen_q     <= '0;
              wdata_q   <= '0;
              ram_ren_q <= 1'b1;
              ram_wen_q <= '0;
            end
          end else begin
            state_q <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_ren   = ram_ren_q;
  assign ram_wen   = ram_wen_q;

  assign iwait = iren && !hit_i;
  assign dwait = d_pend && !hit_d;
  assign iload = hit_i ? ram_rdata : iload_q;
  assign dload = hit_d ? ram_rdata : dload_q;

endmodule : memory_arbiter

// File: tb/tb_memory_arbiter.sv
// Scoreboarded directed bench: instance A uses RAM_LAT=1, instance B uses RAM_LAT=3.
module tb_memory_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  typedef struct {
    logic [31:0] data;
    bit          cmp;
    int unsigned at;
  } exp_t;

  exp_t a_iq[$];
  exp_t a_dq[$];
  exp_t b_dq[$];

  // DUT A (RAM_LAT=1)
  logic        a_iren, a_iwait, a_dren, a_dwait, a_ram_ren;
  logic [31:0] a_iaddr, a_iload, a_daddr, a_dstore, a_dload, a_ram_addr, a_ram_wdata, a_ram_rdata;
  logic [3:0]  a_dwen, a_ram_wen;

  // DUT B (RAM_LAT=3)
  logic        b_iren, b_iwait, b_dren, b_dwait, b_ram_ren;
  logic [31:0] b_iaddr, b_iload, b_daddr, b_dstore, b_dload, b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic [3:0]  b_dwen, b_ram_wen;

  memory_arbiter #(.RAM_LAT(1), .ADDR_W(32), .DATA_W(32)) u_a (
    .clk(clk), .rst(rst),
    .iren(a_iren), .iaddr(a_iaddr), .iload(a_iload), .iwait(a_iwait),
    .dren(a_dren), .dwen(a_dwen), .daddr(a_daddr), .dstore(a_dstore),
    .dload(a_dload), .dwait(a_dwait),
    .ram_addr(a_ram_addr), .ram_ren(a_ram_ren), .ram_wen(a_ram_wen),
    .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
  );

  memory_arbiter #(.RAM_LAT(3), .ADDR_W(32), .DATA_W(32)) u_b (
    .clk(clk), .rst(rst),
    .iren(b_iren), .iaddr(b_iaddr), .iload(b_iload), .iwait(b_iwait),
    .dren(b_dren), .dwen(b_dwen), .daddr(b_daddr), .dstore(b_dstore),
    .dload(b_dload), .dwait(b_dwait),
    .ram_addr(b_ram_addr), .ram_ren(b_ram_ren), .ram_wen(b_ram_wen),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  // RAM models; preload port writes both memories.
  logic        pl_en;
  logic [31:0] pl_addr, pl_data;
  logic [31:0] mem_a [0:16383];
  logic [31:0] mem_b [0:16383];
  logic [31:0] b_p1, b_p2;

  always @(posedge clk) begin
    if (pl_en) mem_a[pl_addr[15:2]] <= pl_data;
    for (int b = 0; b < 4; b++)
      if (a_ram_wen[b]) mem_a[a_ram_addr[15:2]][8*b +: 8] <= a_ram_wdata[8*b +: 8];
    a_ram_rdata <= mem_a[a_ram_addr[15:2]];
  end

  always @(posedge clk) begin
    if (pl_en) mem_b[pl_addr[15:2]] <= pl_data;
    for (int b = 0; b < 4; b++)
      if (b_ram_wen[b]) mem_b[b_ram_addr[15:2]][8*b +: 8] <= b_ram_wdata[8*b +: 8];
    b_p1        <= mem_b[b_ram_addr[15:2]];
    b_p2        <= b_p1;
    b_ram_rdata <= b_p2;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every hit pops the matching scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (a_iren && !a_iwait) begin
      if (a_iq.size() == 0) chk("a_ihit_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      else begin
        e = a_iq.pop_front();
        chk("a_ihit_cycle", 32'(cyc), 32'(e.at));
        if (e.cmp) chk("a_iload", a_iload, e.data);
      end
    end
    if ((a_dren || (|a_dwen)) && !a_dwait) begin
      if (a_dq.size() == 0) chk("a_dhit_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      else begin
        e = a_dq.pop_front();
        chk("a_dhit_cycle", 32'(cyc), 32'(e.at));
        if (e.cmp) chk("a_dload", a_dload, e.data);
      end
    end
    if ((b_dren || (|b_dwen)) && !b_dwait) begin
      if (b_dq.size() == 0) chk("b_dhit_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      else begin
        e = b_dq.pop_front();
        chk("b_dhit_cycle", 32'(cyc), 32'(e.at));
        if (e.cmp) chk("b_dload", b_dload, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [31:0] d, input bit c, input int unsigned at);
    exp_t e;
    e.data = d;
    e.cmp  = c;
    e.at   = at;
    return e;
  endfunction

  logic [31:0] pl_tab_a [0:7];
  logic [31:0] pl_tab_d [0:7];
  int unsigned t;

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    a_iren = 0; a_iaddr = '0; a_dren = 0; a_dwen = '0; a_daddr = '0; a_dstore = '0;
    b_iren = 0; b_iaddr = '0; b_dren = 0; b_dwen = '0; b_daddr = '0; b_dstore = '0;
    pl_tab_a = '{32'h100, 32'h104, 32'h2000, 32'h200, 32'h300, 32'h40, 32'h44, 32'h2004};
    pl_tab_d = '{32'h0000_0013, 32'h0040_0093, 32'h1122_3344, 32'hAAAA_0001,
                 32'hBBBB_0002, 32'hCAFE_0040, 32'hAABB_CCDD, 32'h0000_0000};
    for (int i = 0; i < 8; i++) begin
      step();
      pl_en = 1'b1; pl_addr = pl_tab_a[i]; pl_data = pl_tab_d[i];
    end
    step();
    pl_en = 1'b0;
    mid();
    chk("rst_ram_ren", 32'(a_ram_ren), 32'd0);
    chk("rst_ram_wen", 32'(a_ram_wen), 32'd0);
    chk("rst_ram_addr", a_ram_addr, 32'd0);
    chk("rst_ram_wdata", a_ram_wdata, 32'd0);
    chk("rst_iload", a_iload, 32'd0);
    chk("rst_dload", a_dload, 32'd0);
    chk("rst_iwait_noreq", 32'(a_iwait), 32'd0);
    chk("rst_dwait_noreq", 32'(a_dwait), 32'd0);
    step();
    rst = 1'b0;
    step();

    // 1: single instruction fetch
    step(); t = cyc;
    a_iren = 1; a_iaddr = 32'h100;
    a_iq.push_back(mk(32'h13, 1, t + 2));
    mid(); chk("t1_iwait_req", 32'(a_iwait), 32'd1);
    step(); mid();
    chk("t1_ram_ren", 32'(a_ram_ren), 32'd1);
    chk("t1_ram_addr", a_ram_addr, 32'h100);
    step();
    step(); a_iren = 0;
    mid(); chk("t1_iload_hold", a_iload, 32'h13);
    chk("t1_ram_ren_idle", 32'(a_ram_ren), 32'd0);

    // 2: simultaneous data and instruction requests, data first
    step(); t = cyc;
    a_iren = 1; a_iaddr = 32'h104; a_dren = 1; a_daddr = 32'h2000; a_dstore = '0;
    a_dq.push_back(mk(32'h1122_3344, 1, t + 2));
    a_iq.push_back(mk(32'h0040_0093, 1, t + 4));
    step(); mid(); chk("t2_ram_addr_d", a_ram_addr, 32'h2000);
    step();
    step(); a_dren = 0;
    mid(); chk("t2_ram_addr_i", a_ram_addr, 32'h104);
    chk("t2_ram_ren_i", 32'(a_ram_ren), 32'd1);
    step();
    step(); a_iren = 0;

    // 3: full-word write, then read back
    step(); t = cyc;
    a_dwen = 4'hF; a_daddr = 32'h2004; a_dstore = 32'hDEAD_BEEF;
    a_dq.push_back(mk('0, 0, t + 2));
    step(); mid();
    chk("t3_ram_wen", 32'(a_ram_wen), 32'hF);
    chk("t3_ram_wdata", a_ram_wdata, 32'hDEAD_BEEF);
    chk("t3_ram_ren_wr", 32'(a_ram_ren), 32'd0);
    step(); mid();
    chk("t3_ram_wen_off", 32'(a_ram_wen), 32'd0);
    step(); t = cyc;
    a_dwen = '0; a_dren = 1; a_dstore = '0;
    a_dq.push_back(mk(32'hDEAD_BEEF, 1, t + 2));
    step(); step();
    step(); a_dren = 0;

    // 4: fetch address changes mid-access; stale result discarded
    step(); t = cyc;
    a_iren = 1; a_iaddr = 32'h200;
    step(); a_iaddr = 32'h300;
    a_iq.push_back(mk(32'hBBBB_0002, 1, t + 4));
    step(); mid();
    chk("t4_iwait_stale", 32'(a_iwait), 32'd1);
    chk("t4_iload_kept", a_iload, 32'h0040_0093);
    step(); mid();
    chk("t4_ram_addr_new", a_ram_addr, 32'h300);
    step();
    step(); a_iren = 0;

    // 6: reset during ACCESS, held request restarts
    step(); t = cyc;
    a_iren = 1; a_iaddr = 32'h100;
    step(); rst = 1'b1;
    mid(); chk("t6_ram_ren_access", 32'(a_ram_ren), 32'd1);
    step(); rst = 1'b0; t = cyc;
    a_iq.push_back(mk(32'h13, 1, t + 2));
    mid();
    chk("t6_ram_ren_rst", 32'(a_ram_ren), 32'd0);
    chk("t6_ram_wen_rst", 32'(a_ram_wen), 32'd0);
    chk("t6_iload_rst", a_iload, 32'd0);
    chk("t6_dload_rst", a_dload, 32'd0);
    chk("t6_iwait_rst", 32'(a_iwait), 32'd1);
    step(); step();
    step(); a_iren = 0;

    // 5: RAM_LAT=3 read, then partial write and read-back
    step(); t = cyc;
    b_dren = 1; b_daddr = 32'h40;
    b_dq.push_back(mk(32'hCAFE_0040, 1, t + 4));
    for (int k = 1; k <= 3; k++) begin
      step(); mid();
      chk("t5_ram_ren", 32'(b_ram_ren), 32'd1);
      chk("t5_ram_addr", b_ram_addr, 32'h40);
      chk("t5_dwait", 32'(b_dwait), 32'd1);
    end
    step();
    step(); b_dren = 0;
    step(); t = cyc;
    b_dwen = 4'b0011; b_daddr = 32'h44; b_dstore = 32'h1234_5678;
    b_dq.push_back(mk('0, 0, t + 4));
    step(); mid(); chk("t5_wen_first", 32'(b_ram_wen), 32'h3);
    step(); mid(); chk("t5_wen_second", 32'(b_ram_wen), 32'h0);
    step(); mid(); chk("t5_wen_third", 32'(b_ram_wen), 32'h0);
    step();
    step(); t = cyc;
    b_dwen = '0; b_dren = 1; b_dstore = '0;
    b_dq.push_back(mk(32'hAABB_5678, 1, t + 4));
    repeat (4) step();
    step(); b_dren = 0;

    repeat (4) step();
    chk("a_iq_drained", 32'(a_iq.size()), 32'd0);
    chk("a_dq_drained", 32'(a_dq.size()), 32'd0);
    chk("b_dq_drained", 32'(b_dq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_memory_arbiter
